// File: rtl/pll_bringup_sequencer.sv
// ============================================================================
// Module   : pll_bringup_sequencer
// Purpose  : PLL bring-up sequencer. Pulses the PLL areset, qualifies the
//            synchronized locked conduit, and releases the core's active-low
//            reset only after a filtered lock plus a hold-off. Lock loss in
//            RUN restarts the sequence. Repeated lock timeouts end in a
//            sticky FAULT.
// Options  : PLL_LOSS_COUNT_EN - when defined, loss_count is an 8-bit
//            saturating count of RUN lock losses. Otherwise it reads 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_bringup_sequencer #(
    parameter int AR_CYCLES    = 16,
    parameter int LOCK_FILTER  = 8,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int HOLD_CYCLES  = 256,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                               clk_clk,
    input  logic                               reset_reset,
    input  logic                               pll_locked,
    input  logic                               relock_req,
    output logic                               pll_areset,
    output logic                               sys_reset_n,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [7:0]                         loss_count
);

    // One shared phase counter serves ARESET length, WAIT_LOCK timeout and
    // HOLD length; it is cleared on every state change, so it only has to
    // hold the largest of the three terminal values.
    localparam int CNT_MAX0 = (AR_CYCLES > HOLD_CYCLES) ? AR_CYCLES : HOLD_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > LOCK_TIMEOUT) ? CNT_MAX0 : LOCK_TIMEOUT;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int FILT_W   = $clog2(LOCK_FILTER + 1);
    localparam int RETRY_W  = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   C_AR_LAST   = CNT_W'(AR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   C_TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [FILT_W-1:0]  C_FILT_DONE = FILT_W'(LOCK_FILTER);
    localparam logic [RETRY_W-1:0] C_RETRY_MAX = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_ARESET    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FILT_W-1:0]   filt_q, filt_d, filt_next;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                sync1_q, locked_s_q;
    logic                pll_areset_q, sys_reset_n_q, ready_q, fault_q;

    // Two-flop synchronizer for the asynchronous locked conduit.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q       <= ST_ARESET;
            cnt_q         <= '0;
            filt_q        <= '0;
            retry_q       <= '0;
            pll_areset_q  <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            filt_q        <= filt_d;
            retry_q       <= retry_d;
            // Outputs decode the next state so they change on the same edge.
            pll_areset_q  <= (state_d == ST_ARESET) || (state_d == ST_FAULT);
            sys_reset_n_q <= (state_d == ST_RUN);
            ready_q       <= (state_d == ST_RUN);
            fault_q       <= (state_d == ST_FAULT);
        end
    end

    // Next-state logic; relock_req only matters in RUN and FAULT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        filt_d    = filt_q;
        retry_d   = retry_q;
        filt_next = locked_s_q ? (filt_q + FILT_W'(1)) : '0;

        case (state_q)
            ST_ARESET: begin
                if (cnt_q == C_AR_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    filt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // A qualified lock wins over a timeout landing on the same cycle.
                if (filt_next == C_FILT_DONE) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    filt_d  = '0;
                end else if (cnt_q == C_TMO_LAST) begin
                    cnt_d  = '0;
                    filt_d = '0;
                    if (retry_q == C_RETRY_MAX) begin
                        state_d = ST_FAULT;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_ARESET;
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    filt_d = filt_next;
                end
            end
            ST_HOLD: begin
                if (!locked_s_q) begin
                    state_d = ST_ARESET;
                    cnt_d   = '0;
                end else if (cnt_q == C_HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!locked_s_q || relock_req) begin
                    state_d = ST_ARESET;
                    cnt_d   = '0;
                end
            end
            ST_FAULT: begin
                if (relock_req) begin
                    state_d = ST_ARESET;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_ARESET;
                cnt_d   = '0;
                filt_d  = '0;
            end
        endcase
    end

`ifdef PLL_LOSS_COUNT_EN
    logic       loss_evt;
    logic [7:0] loss_q;

    // Lock loss in RUN has priority over relock_req, so this is exactly the
    // RUN->ARESET edge caused by locked_s falling.
    assign loss_evt = (state_q == ST_RUN) && !locked_s_q;

    // Saturating lock-loss counter; only reset_reset clears it.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            loss_q <= 8'd0;
        end else if (loss_evt && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_count = loss_q;
`else
    assign loss_count = 8'd0;
`endif

    assign pll_areset  = pll_areset_q;
    assign sys_reset_n = sys_reset_n_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;

endmodule

`default_nettype wire
